// File: rtl/uart_seq_detect_pkg.sv
// uart_seq_detect_pkg
//   Shared defaults for the UART command-sequence detector and its
//   pulse stretcher: the AA BB CC DD EE soft-reset sequence, the default
//   output pulse width and inter-byte timeout, plus a width helper.
package uart_seq_detect_pkg;

   localparam int DEF_SEQ_LEN = 5;
   localparam int DEF_NUM_CMD = 2;
   localparam logic [39:0] DEF_SOFT_RESET_SEQ = 40'hAABBCCDDEE;
   localparam logic [79:0] DEF_CMD_SEQ = {DEF_SOFT_RESET_SEQ, 40'h1122334455};
   localparam int DEF_PULSE_W = 4;
   localparam int DEF_TIMEOUT = 1000;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pulse_stretch.sv
// pulse_stretch
//   Turns a one-cycle trigger into an active-low pulse WIDTH cycles long.
//   A trigger during a pulse reloads the counter, extending the pulse.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset (forces out_n high)
//     trig  - one-cycle load request
//     out_n - registered active-low pulse, low for WIDTH cycles after trig
module pulse_stretch
   import uart_seq_detect_pkg::*;
#(
   parameter int WIDTH = DEF_PULSE_W
)(
   input  logic clk,
   input  logic rst_n,
   input  logic trig,
   output logic out_n
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   // out_n is its own flop rather than decoded from cnt, so the line
   // cannot glitch while the counter bits change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         out_n <= 1'b1;
      end else if (trig) begin
         cnt   <= CNT_LOAD;
         out_n <= 1'b0;
      end else begin
         if (cnt != '0)
            cnt <= cnt - CNT_ONE;
         // Next count is non-zero only while the current one exceeds one.
         out_n <= !(cnt > CNT_ONE);
      end
   end

endmodule

// File: rtl/uart_seq_detect.sv
// uart_seq_detect
//   Matches the UART RX byte stream against NUM_CMD programmable sequences
//   of SEQ_LEN bytes. A match raises hit_valid for one cycle with the
//   command index on hit_id and starts a PULSE_W-cycle low pulse on
//   hit_n[index]. Partial sequences are discarded after TIMEOUT idle
//   cycles (0 disables this).
//   Ports:
//     clk       - system clock
//     rst_n     - asynchronous active-low reset
//     clr       - synchronous history flush (pulses in progress continue)
//     valid     - one-cycle byte strobe
//     din       - received byte
//     hit_valid - one-cycle match strobe
//     hit_id    - index of the last matched command
//     hit_n     - per-command active-low stretched pulse
module uart_seq_detect
   import uart_seq_detect_pkg::*;
#(
   parameter int SEQ_LEN = DEF_SEQ_LEN,
   parameter int NUM_CMD = DEF_NUM_CMD,
   parameter logic [NUM_CMD*SEQ_LEN*8-1:0] CMD_SEQ = DEF_CMD_SEQ,
   parameter int PULSE_W = DEF_PULSE_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          valid,
   input  logic [7:0]                    din,
   output logic                          hit_valid,
   output logic [idx_width(NUM_CMD)-1:0] hit_id,
   output logic [NUM_CMD-1:0]            hit_n
);

   localparam int SHIFT_W = SEQ_LEN * 8;
   localparam int FILL_W  = $clog2(SEQ_LEN + 1);
   localparam int ID_W    = idx_width(NUM_CMD);
   localparam int GAP_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
   localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(TIMEOUT);

   logic [SHIFT_W-1:0] shift, base_shift, shift_next;
   logic [FILL_W-1:0]  fill, base_fill, fill_next;
   logic [GAP_W-1:0]   gap;
   logic               timed_out;
   logic               match;
   logic [ID_W-1:0]    match_id;
   logic [NUM_CMD-1:0] trig;

   assign timed_out = (TIMEOUT != 0) && (gap == GAP_MAX);

   always_comb begin
      // A byte arriving after the timeout starts from an empty history.
      base_shift = timed_out ? '0 : shift;
      base_fill  = timed_out ? '0 : fill;
      shift_next = base_shift << 8;
      shift_next[7:0] = din;
      fill_next  = (base_fill == FILL_FULL) ? FILL_FULL : base_fill + 1'b1;

      // Scan from the top index down so the lowest matching index wins.
      match    = 1'b0;
      match_id = '0;
      for (int i = NUM_CMD - 1; i >= 0; i--) begin
         if (fill_next == FILL_FULL && shift_next == CMD_SEQ[i*SHIFT_W +: SHIFT_W]) begin
            match    = 1'b1;
            match_id = ID_W'(i);
         end
      end

      trig = '0;
      if (valid && !clr && match)
         trig[match_id] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift     <= '0;
         fill      <= '0;
         gap       <= '0;
         hit_valid <= 1'b0;
         hit_id    <= '0;
      end else begin
         hit_valid <= |trig;
         if (|trig)
            hit_id <= match_id;

         if (clr) begin
            fill <= '0;
            gap  <= '0;
         end else if (valid) begin
            shift <= shift_next;
            gap   <= '0;
            // Clearing on a hit keeps matches non-overlapping.
            fill  <= match ? '0 : fill_next;
         end else if (gap != GAP_MAX) begin
            gap <= gap + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CMD; g++) begin : g_pulse
      pulse_stretch #(
         .WIDTH (PULSE_W)
      ) u_pulse (
         .clk   (clk),
         .rst_n (rst_n),
         .trig  (trig[g]),
         .out_n (hit_n[g])
      );
   end

endmodule

// File: tb/tb_uart_seq_detect.sv
module tb_uart_seq_detect;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       valid, valid2;
   logic [7:0] din, din2;
   logic       hit_valid, hit_valid2;
   logic [0:0] hit_id, hit_id2;
   logic [1:0] hit_n, hit_n2;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   // Main instance: id0 = AA BB CC DD EE, id1 = 11 22 33 44 55.
   uart_seq_detect #(
      .SEQ_LEN (5),
      .NUM_CMD (2),
      .CMD_SEQ ({40'h1122334455, 40'hAABBCCDDEE}),
      .PULSE_W (4),
      .TIMEOUT (1000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .valid     (valid),
      .din       (din),
      .hit_valid (hit_valid),
      .hit_id    (hit_id),
      .hit_n     (hit_n)
   );

   // Single-byte commands for pulse-extension checks: id0 = 5A, id1 = EE.
   uart_seq_detect #(
      .SEQ_LEN (1),
      .NUM_CMD (2),
      .CMD_SEQ ({8'hEE, 8'h5A}),
      .PULSE_W (4),
      .TIMEOUT (0)
   ) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .valid     (valid2),
      .din       (din2),
      .hit_valid (hit_valid2),
      .hit_id    (hit_id2),
      .hit_n     (hit_n2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      valid = 1'b1;
      din   = b;
      tick();
      valid = 1'b0;
   endtask

   task automatic send2(input logic [7:0] b);
      valid2 = 1'b1;
      din2   = b;
      tick();
      valid2 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      valid = 1'b0; din = 8'h00;
      valid2 = 1'b0; din2 = 8'h00;
      repeat (2) tick();
      chk("rst_hit_valid", 32'(hit_valid), 32'd0);
      chk("rst_hit_id",    32'(hit_id),    32'd0);
      chk("rst_hit_n",     32'(hit_n),     32'h3);
      chk("rst_hit_n2",    32'(hit_n2),    32'h3);
      rst_n = 1'b1;
      tick();

      // Back-to-back soft-reset sequence.
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      chk("b2b_no_early_hit", 32'(hit_valid), 32'd0);
      send(8'hEE);
      chk("b2b_hit_valid", 32'(hit_valid), 32'd1);
      chk("b2b_hit_id",    32'(hit_id),    32'd0);
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("b2b_hit_n_c%0d", c), 32'(hit_n), 32'h2);
         tick();
      end
      chk("b2b_hit_n_end",  32'(hit_n),     32'h3);
      chk("b2b_strobe_end", 32'(hit_valid), 32'd0);

      // Second command with 10-cycle gaps.
      send(8'h11); repeat (10) tick();
      send(8'h22); repeat (10) tick();
      send(8'h33); repeat (10) tick();
      send(8'h44); repeat (10) tick();
      send(8'h55);
      chk("gap10_hit_valid", 32'(hit_valid), 32'd1);
      chk("gap10_hit_id",    32'(hit_id),    32'd1);
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("gap10_hit_n_c%0d", c), 32'(hit_n), 32'h1);
         tick();
      end
      chk("gap10_hit_n_end", 32'(hit_n), 32'h3);

      // Exactly TIMEOUT idle cycles before the last byte: restart, no hit.
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      repeat (1000) tick();
      send(8'hEE);
      chk("to1000_no_hit",   32'(hit_valid), 32'd0);
      chk("to1000_hit_n",    32'(hit_n),     32'h3);
      // TIMEOUT-1 idle cycles: sequence continues.
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      repeat (999) tick();
      send(8'hEE);
      chk("to999_hit_valid", 32'(hit_valid), 32'd1);
      chk("to999_hit_id",    32'(hit_id),    32'd0);
      repeat (5) tick();

      // Leading junk, then a repeated final byte must not rematch.
      send(8'hAA); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      send(8'hEE);
      chk("junk_hit_valid", 32'(hit_valid), 32'd1);
      chk("junk_hit_id",    32'(hit_id),    32'd0);
      send(8'hEE);
      chk("nonoverlap_no_hit", 32'(hit_valid), 32'd0);
      repeat (6) tick();

      // Asynchronous reset mid-pulse (history holds EE, fill 1 here).
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
      chk("arst_pre_hit_n", 32'(hit_n), 32'h2);
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_hit_n",     32'(hit_n),     32'h3);
      chk("arst_hit_valid", 32'(hit_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // clr together with the final byte drops it and flushes history.
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
      clr = 1'b1; valid = 1'b1; din = 8'hEE;
      tick();
      clr = 1'b0; valid = 1'b0;
      chk("clr_no_hit",   32'(hit_valid), 32'd0);
      chk("clr_hit_n",    32'(hit_n),     32'h3);
      send(8'hEE);
      chk("clr_flushed",  32'(hit_valid), 32'd0);
      repeat (2) tick();

      // Single-byte instance: id0 command and pulse extension on id1.
      send2(8'h5A);
      chk("s1_id0_valid", 32'(hit_valid2), 32'd1);
      chk("s1_id0_id",    32'(hit_id2),    32'd0);
      chk("s1_id0_hit_n", 32'(hit_n2),     32'h2);
      repeat (5) tick();
      chk("s1_id0_end",   32'(hit_n2),     32'h3);
      send2(8'hEE);
      chk("ext_first_id",    32'(hit_id2), 32'd1);
      chk("ext_first_hit_n", 32'(hit_n2),  32'h1);
      tick();
      chk("ext_gap_hit_n",   32'(hit_n2),  32'h1);
      send2(8'hEE);
      chk("ext_second_valid", 32'(hit_valid2), 32'd1);
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("ext_hit_n_c%0d", c), 32'(hit_n2), 32'h1);
         tick();
      end
      chk("ext_hit_n_end", 32'(hit_n2), 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
